// File: rtl/break_select_controller_pkg.sv
// rtl/break_select_controller_pkg.sv - shared states, index width and write-enable encodings
package break_select_controller_pkg;

    // Only a three-literal clause is supported; the top refuses any other NSAT.
    localparam int NSAT_SUPPORTED = 3;
    localparam int NSAT_BITS      = $clog2(NSAT_SUPPORTED);

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_FETCH    = 3'd1;
    localparam state_t ST_SELECT   = 3'd2;
    localparam state_t ST_SEL_WAIT = 3'd3;
    localparam state_t ST_CAPTURE  = 3'd4;
    localparam state_t ST_FLIP     = 3'd5;

    // Datapath write-enable encodings: zero is idle, all-ones asks the selector to pick.
    localparam logic [NSAT_BITS-1:0] WREN_IDLE   = '0;
    localparam logic [NSAT_BITS-1:0] WREN_SELECT = '1;

endpackage

// File: rtl/break_select_controller_lit_next_valid.sv
// rtl/break_select_controller_lit_next_valid.sv - finds the lowest valid literal at or above a start index
module lit_next_valid
    import break_select_controller_pkg::*;
#(
    parameter int NSAT     = 3,
    parameter int IDX_BITS = NSAT_BITS
) (
    input  logic [NSAT-1:0]     valid_i,
    input  logic [IDX_BITS-1:0] start_idx_i,
    output logic                found_o,
    output logic [IDX_BITS-1:0] idx_o
);

    // Scan from the top down so the last hit written is the lowest qualifying index.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NSAT - 1; i >= 0; i--) begin
            if (valid_i[i] && (IDX_BITS'(i) >= start_idx_i)) begin
                found_o = 1'b1;
                idx_o   = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/break_select_controller.sv
// rtl/break_select_controller.sv - sequences per-literal fetches, selection and flip handoff for one clause
module break_select_controller
    import break_select_controller_pkg::*;
#(
    parameter int NSAT     = 3,
    parameter int VAR_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [NSAT*VAR_BITS-1:0] clause_vars_i,
    input  logic [NSAT-1:0]          clause_lit_valid_i,
    output logic                     fetch_req_o,
    output logic [VAR_BITS-1:0]      fetch_var_o,
    input  logic                     fetch_ack_i,
    output logic [NSAT_BITS-1:0]     wren_o,
    output logic [NSAT-1:0]          break_values_valid_o,
    input  logic [NSAT_BITS-1:0]     select_i,
    output logic                     flip_valid_o,
    output logic [VAR_BITS-1:0]      flip_var_o,
    input  logic                     flip_ready_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     error_o
);

    generate
        if (NSAT != NSAT_SUPPORTED) begin : g_nsat_check
            $error("break_select_controller supports only NSAT=3");
        end
    endgenerate

    localparam logic [NSAT_BITS-1:0] K_LAST = NSAT_BITS'(NSAT - 1);

    state_t                           state_q, state_d;
    logic [NSAT_BITS-1:0]             k_q, k_d;
    logic [NSAT-1:0][VAR_BITS-1:0]    vars_q;
    logic [NSAT-1:0]                  valid_q;
    logic [VAR_BITS-1:0]              flip_var_q;
    logic                             error_q, error_d;
    logic                             init_q;
    logic                             latch_en;
    logic                             capture_en;

    logic [NSAT-1:0]                  find_valid;
    logic [NSAT_BITS-1:0]             find_start;
    logic                             find_found;
    logic [NSAT_BITS-1:0]             find_idx;
    logic [VAR_BITS-1:0]              sel_var;

    // In IDLE the finder looks at the incoming clause from slot 0; while fetching it
    // looks at the latched mask from the slot after the current one.
    assign find_valid = (state_q == ST_IDLE) ? clause_lit_valid_i : valid_q;
    assign find_start = (state_q == ST_IDLE) ? '0 : (k_q + NSAT_BITS'(1));

    lit_next_valid #(
        .NSAT     (NSAT),
        .IDX_BITS (NSAT_BITS)
    ) u_next (
        .valid_i     (find_valid),
        .start_idx_i (find_start),
        .found_o     (find_found),
        .idx_o       (find_idx)
    );

    // An out-of-range winner index captures zero rather than an undefined slot.
    assign sel_var = (select_i <= K_LAST) ? vars_q[select_i] : '0;

    // Next-state decision; abort overrides every transition including an ack.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && init_q) begin
                    if (find_found) begin
                        latch_en = 1'b1;
                        k_d      = find_idx;
                        state_d  = ST_FETCH;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (fetch_ack_i) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_SEL_WAIT;
                    end else if (find_found) begin
                        k_d = find_idx;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SELECT:   state_d = ST_SEL_WAIT;
            ST_SEL_WAIT: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                capture_en = 1'b1;
                state_d    = ST_FLIP;
            end
            ST_FLIP: begin
                if (flip_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d    = ST_IDLE;
            latch_en   = 1'b0;
            capture_en = 1'b0;
            error_d    = 1'b0;
        end
    end

    // Output decode; an abort blanks everything in the cycle it is raised.
    always_comb begin
        fetch_req_o          = 1'b0;
        fetch_var_o          = '0;
        wren_o               = WREN_IDLE;
        flip_valid_o         = 1'b0;
        busy_o               = 1'b0;
        break_values_valid_o = '0;
        if (!abort_i) begin
            busy_o = (state_q != ST_IDLE);
            case (state_q)
                ST_FETCH: begin
                    fetch_req_o = 1'b1;
                    fetch_var_o = vars_q[k_q];
                    if (fetch_ack_i) begin
                        wren_o = (k_q == K_LAST) ? WREN_SELECT : (NSAT_BITS'(1) << k_q);
                    end
                end
                ST_SELECT: wren_o = WREN_SELECT;
                ST_FLIP:   flip_valid_o = 1'b1;
                default:   ;
            endcase
            if (wren_o == WREN_SELECT) begin
                break_values_valid_o = valid_q;
            end
        end
    end

    assign error_o    = error_q & ~abort_i;
    assign flip_var_o = abort_i ? '0 : flip_var_q;

    // State, latched clause, captured winner and the post-reset start guard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            vars_q     <= '0;
            valid_q    <= '0;
            flip_var_q <= '0;
            error_q    <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            init_q  <= 1'b1;
            state_q <= state_d;
            k_q     <= k_d;
            error_q <= error_d;
            if (latch_en) begin
                vars_q  <= clause_vars_i;
                valid_q <= clause_lit_valid_i;
            end
            if (abort_i) begin
                flip_var_q <= '0;
            end else if (capture_en) begin
                flip_var_q <= sel_var;
            end
        end
    end

endmodule

// File: tb/tb_break_select_controller.sv
// tb/tb_break_select_controller.sv - directed bench for break_select_controller
module tb_break_select_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] vars;
    logic [2:0]  valid;
    logic        fetch_req;
    logic [7:0]  fetch_var;
    logic        ack;
    logic [1:0]  wren;
    logic [2:0]  bvv;
    logic [1:0]  sel;
    logic        flip_valid;
    logic [7:0]  flip_var;
    logic        ready;
    logic        abort;
    logic        busy;
    logic        err;

    int errors;
    int checks;

    break_select_controller #(
        .NSAT     (3),
        .VAR_BITS (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start_i              (start),
        .clause_vars_i        (vars),
        .clause_lit_valid_i   (valid),
        .fetch_req_o          (fetch_req),
        .fetch_var_o          (fetch_var),
        .fetch_ack_i          (ack),
        .wren_o               (wren),
        .break_values_valid_o (bvv),
        .select_i             (sel),
        .flip_valid_o         (flip_valid),
        .flip_var_o           (flip_var),
        .flip_ready_i         (ready),
        .abort_i              (abort),
        .busy_o               (busy),
        .error_o              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        start  = 1'b0;
        vars   = '0;
        valid  = '0;
        ack    = 1'b0;
        sel    = '0;
        ready  = 1'b0;
        abort  = 1'b0;

        nc(); #1;
        check("rst_busy", busy, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_wren", wren, 0);
        check("rst_flip_valid", flip_valid, 0);
        check("rst_flip_var", flip_var, 0);
        check("rst_error", err, 0);

        // release reset with a start already presented: must be ignored
        nc(); reset = 1'b1; vars = {8'd12, 8'd9, 8'd5}; valid = 3'b111; start = 1'b1; #1;
        nc(); start = 1'b0; #1;
        check("post_rst_start_ignored", busy, 0);

        // all valid, immediate acks, winner 2
        nc(); sel = 2'd2; ack = 1'b1; start = 1'b1; #1;
        check("t1_idle_busy", busy, 0);
        nc(); start = 1'b0; #1;
        check("t1_c1_req", fetch_req, 1);
        check("t1_c1_var", fetch_var, 5);
        check("t1_c1_wren", wren, 2'b01);
        check("t1_c1_bvv", bvv, 0);
        nc(); #1;
        check("t1_c2_var", fetch_var, 9);
        check("t1_c2_wren", wren, 2'b10);
        nc(); #1;
        check("t1_c3_var", fetch_var, 12);
        check("t1_c3_wren", wren, 2'b11);
        check("t1_c3_bvv", bvv, 3'b111);
        nc(); #1;
        check("t1_c4_wren", wren, 0);
        check("t1_c4_busy", busy, 1);
        nc(); #1;
        check("t1_c5_flip_valid", flip_valid, 0);
        nc(); ready = 1'b1; start = 1'b1; #1;
        check("t1_c6_flip_valid", flip_valid, 1);
        check("t1_c6_flip_var", flip_var, 12);
        nc(); ready = 1'b0; start = 1'b0; #1;
        check("t1_c7_busy", busy, 0);
        check("t1_c7_flip_valid", flip_valid, 0);

        // valid 101 and a stalled consumer
        nc(); vars = {8'h33, 8'h22, 8'h11}; valid = 3'b101; sel = 2'd0; start = 1'b1; #1;
        nc(); start = 1'b0; #1;
        check("t2_c1_var", fetch_var, 8'h11);
        check("t2_c1_wren", wren, 2'b01);
        nc(); #1;
        check("t2_c2_var", fetch_var, 8'h33);
        check("t2_c2_wren", wren, 2'b11);
        check("t2_c2_bvv", bvv, 3'b101);
        nc(); #1;
        check("t2_c3_wren", wren, 0);
        nc(); #1;
        nc(); #1;
        check("t2_flip_valid", flip_valid, 1);
        check("t2_flip_var", flip_var, 8'h11);
        for (int i = 0; i < 5; i++) begin
            nc(); sel = 2'd2; #1;
            check("t2_hold_valid", flip_valid, 1);
            check("t2_hold_var", flip_var, 8'h11);
        end
        nc(); ready = 1'b1; #1;
        nc(); ready = 1'b0; #1;
        check("t2_done_busy", busy, 0);

        // valid 011 ends in a SELECT cycle
        nc(); vars = {8'h63, 8'h42, 8'h21}; valid = 3'b011; sel = 2'd1; start = 1'b1; #1;
        nc(); start = 1'b0; #1;
        check("t3_c1_var", fetch_var, 8'h21);
        check("t3_c1_wren", wren, 2'b01);
        nc(); #1;
        check("t3_c2_var", fetch_var, 8'h42);
        check("t3_c2_wren", wren, 2'b10);
        nc(); #1;
        check("t3_sel_wren", wren, 2'b11);
        check("t3_sel_req", fetch_req, 0);
        check("t3_sel_bvv", bvv, 3'b011);
        check("t3_sel_busy", busy, 1);
        nc(); #1;
        check("t3_c4_wren", wren, 0);
        nc(); #1;
        nc(); ready = 1'b1; #1;
        check("t3_flip_valid", flip_valid, 1);
        check("t3_flip_var", flip_var, 8'h42);
        nc(); ready = 1'b0; #1;
        check("t3_done_busy", busy, 0);

        // no valid literal
        nc(); valid = 3'b000; start = 1'b1; #1;
        check("t4_err_c0", err, 0);
        nc(); start = 1'b0; #1;
        check("t4_err_c1", err, 1);
        check("t4_busy_c1", busy, 0);
        check("t4_req_c1", fetch_req, 0);
        nc(); #1;
        check("t4_err_c2", err, 0);
        check("t4_busy_c2", busy, 0);

        // abort on the second ack, then a normal decision with a late first ack
        nc(); vars = {8'd3, 8'd2, 8'd1}; valid = 3'b111; sel = 2'd1; ack = 1'b1; start = 1'b1; #1;
        nc(); start = 1'b0; #1;
        check("t5_c1_wren", wren, 2'b01);
        nc(); abort = 1'b1; #1;
        check("t5_abort_wren", wren, 0);
        check("t5_abort_req", fetch_req, 0);
        check("t5_abort_busy", busy, 0);
        nc(); abort = 1'b0; #1;
        check("t5_idle_busy", busy, 0);
        check("t5_idle_req", fetch_req, 0);
        nc(); ack = 1'b0; start = 1'b1; #1;
        nc(); start = 1'b0; #1;
        check("t5_wait_req", fetch_req, 1);
        check("t5_wait_var", fetch_var, 1);
        check("t5_wait_wren", wren, 0);
        nc(); ack = 1'b1; #1;
        check("t5_r1_wren", wren, 2'b01);
        nc(); #1;
        check("t5_r2_wren", wren, 2'b10);
        check("t5_r2_var", fetch_var, 2);
        nc(); #1;
        check("t5_r3_wren", wren, 2'b11);
        nc(); #1;
        nc(); #1;
        nc(); ready = 1'b1; #1;
        check("t5_flip_valid", flip_valid, 1);
        check("t5_flip_var", flip_var, 2);
        nc(); ready = 1'b0; #1;
        check("t5_done_busy", busy, 0);

        // reset while fetching
        nc(); ack = 1'b0; start = 1'b1; #1;
        nc(); start = 1'b0; #1;
        check("t6_pre_req", fetch_req, 1);
        reset = 1'b0; #1;
        check("t6_rst_req", fetch_req, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_fetch_var", fetch_var, 0);
        check("t6_rst_wren", wren, 0);
        check("t6_rst_flip_var", flip_var, 0);
        check("t6_rst_flip_valid", flip_valid, 0);
        nc(); reset = 1'b1; #1;
        nc(); #1;
        check("t6_after_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
